// File: rtl/stream_pkg.sv
// stream_pkg: shared types, defaults and slice-size decode for the stream reorder engine
package stream_pkg;
   localparam int WORD_W_DEF = 32;
   typedef enum logic [2:0] {SL1, SL2, SL4, SL8, SL16, SL_PASS} slice_e;
   typedef enum logic {IDLE, HOLD} state_e;
   function automatic slice_e decode_slice(input logic [2:0] cfg);
      return (cfg > 3'd4) ? SL_PASS : slice_e'(cfg);
   endfunction
endpackage

// File: rtl/stream_slice_rev.sv
// stream_slice_rev: combinational left-stream slice reversal ({<< S {data}}) at a selectable slice size
//   data     in  W   word to reorder
//   slice    in      slice size select, SL_PASS returns data unchanged
//   reversed out W   data with slice order reversed, bits inside a slice kept
module stream_slice_rev import stream_pkg::*; #(
   parameter int W = 32
) (
   input  logic [W-1:0] data,
   input  slice_e       slice,
   output logic [W-1:0] reversed
);
   logic [4:0][W-1:0] r;
   for (genvar s = 0; s < 5; s++) begin : g_s
      localparam int SZ = 1 << s;
      localparam int N = W / SZ;
      for (genvar k = 0; k < N; k++) begin : g_k
         assign r[s][k*SZ +: SZ] = data[(N-1-k)*SZ +: SZ];
      end
   end
   always_comb
      reversed = slice == SL1  ? r[0] :
                 slice == SL2  ? r[1] :
                 slice == SL4  ? r[2] :
                 slice == SL8  ? r[3] :
                 slice == SL16 ? r[4] : data;
endmodule

// File: rtl/stream_reorder_ctrl.sv
// stream_reorder_ctrl: sequenced slice-reversal engine with optional two-beat pairing and registered output
//   clk, rst_n              clock, async active-low reset
//   cfg_slice, cfg_pair     slice size and pairing mode, latched on the first beat of an operation
//   in_valid/in_ready/in_data       input word stream
//   out_valid/out_ready/out_data    result stream, out_wide marks a paired result
//   busy, op_count          activity flag and count of completed output handshakes
module stream_reorder_ctrl import stream_pkg::*; #(
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          cfg_slice,
   input  logic                cfg_pair,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*WORD_W-1:0] out_data,
   output logic                out_wide,
   output logic                busy,
   output logic [CNT_W-1:0]    op_count
);
   state_e              state_q;
   slice_e              cfg_q;
   slice_e              slice_now;
   logic [WORD_W-1:0]   hold_q;
   logic [2*WORD_W-1:0] out_data_q, out_data_d;
   logic                out_valid_q, out_wide_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WORD_W-1:0]   single_rev;
   logic [2*WORD_W-1:0] pair_rev;
   logic                accept, fin, hs;
   assign slice_now = decode_slice(cfg_slice);
   assign in_ready  = !out_valid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign hs        = out_valid_q & out_ready;
   // a beat finishes an operation when it is the second of a pair or a lone single
   assign fin       = accept & ((state_q == HOLD) | !cfg_pair);
   stream_slice_rev #(.W(WORD_W)) u_rev_single (
      .data(in_data), .slice(slice_now), .reversed(single_rev)
   );
   stream_slice_rev #(.W(2*WORD_W)) u_rev_pair (
      .data({hold_q, in_data}), .slice(cfg_q), .reversed(pair_rev)
   );
   always_comb
      out_data_d = (state_q == HOLD) ? pair_rev : {{WORD_W{1'b0}}, single_rev};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cfg_q       <= SL1;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_wide_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cnt_q       <= cnt_q + CNT_W'(hs);
         out_valid_q <= fin | (out_valid_q & !out_ready);
         if (fin) begin
            out_data_q <= out_data_d;
            out_wide_q <= state_q == HOLD;
         end
         if (accept && state_q == IDLE)
            cfg_q <= slice_now;
         if (accept && state_q == IDLE && cfg_pair) begin
            hold_q  <= in_data;
            state_q <= HOLD;
         end else if (accept) begin
            state_q <= IDLE;
         end
      end
   end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_wide  = out_wide_q;
   assign busy      = (state_q == HOLD) | out_valid_q;
   assign op_count  = cnt_q;
endmodule

// File: tb/tb_stream_reorder_ctrl.sv
// tb_stream_reorder_ctrl: directed bench with a streaming-operator reference model checked every cycle
module tb_stream_reorder_ctrl;
   logic        clk = 0;
   logic        rst_n = 1;
   logic [2:0]  cfg_slice = 0;
   logic        cfg_pair = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [31:0] in_data = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [63:0] out_data;
   logic        out_wide;
   logic        busy;
   logic [15:0] op_count;
   int tests = 0;
   int fails = 0;

   stream_reorder_ctrl #(.WORD_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_slice(cfg_slice), .cfg_pair(cfg_pair),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_wide(out_wide), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mrev32(input logic [31:0] x, input int s);
      logic [31:0] r;
      case (s)
         0: r = {<<{x}};
         1: r = {<<2{x}};
         2: r = {<<4{x}};
         3: r = {<<8{x}};
         4: r = {<<16{x}};
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] mrev64(input logic [63:0] x, input int s);
      logic [63:0] r;
      case (s)
         0: r = {<<{x}};
         1: r = {<<2{x}};
         2: r = {<<4{x}};
         3: r = {<<8{x}};
         4: r = {<<16{x}};
         default: r = x;
      endcase
      return r;
   endfunction

   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   bit          m_hold_st = 0;
   logic [31:0] m_hold = 0;
   int          m_slice = 0;
   bit          m_valid = 0;
   logic [63:0] m_data = 0;
   bit          m_wide = 0;
   logic [15:0] m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold_st = 0; m_hold = 0; m_valid = 0; m_data = 0; m_wide = 0; m_cnt = 0;
      end else begin
         bit take;
         take = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready) begin
            m_cnt++;
            m_valid = 0;
         end
         if (take && m_hold_st) begin
            m_data = mrev64({m_hold, in_data}, m_slice);
            m_wide = 1; m_valid = 1; m_hold_st = 0;
         end else if (take) begin
            m_slice = int'(cfg_slice);
            if (cfg_pair) begin
               m_hold = in_data; m_hold_st = 1;
            end else begin
               m_data = {32'h0, mrev32(in_data, int'(cfg_slice))};
               m_wide = 0; m_valid = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(m_hold_st || m_valid));
      check("op_count", 64'(op_count), 64'(m_cnt));
      if (m_valid) begin
         check("out_data", out_data, m_data);
         check("out_wide", 64'(out_wide), 64'(m_wide));
      end
   end

   task automatic send(input logic [31:0] d, input logic [2:0] s, input logic p);
      bit acc;
      int n;
      n = 0;
      in_data = d; cfg_slice = s; cfg_pair = p; in_valid = 1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end while (!acc && n < 50);
      if (!acc) check("accept_timeout", 64'(acc), 64'(1));
      #1 in_valid = 0;
   endtask

   task automatic expect_out(input string n, input logic [63:0] e, input logic w);
      @(negedge clk);
      check({n, "_valid"}, 64'(out_valid), 64'(1));
      check({n, "_data"}, out_data, e);
      check({n, "_wide"}, 64'(out_wide), 64'(w));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_wide", 64'(out_wide), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_op_count", 64'(op_count), 64'(0));
      @(posedge clk);
      #1 rst_n = 1; out_ready = 1;
      send(32'h172A7FFF, 3'd3, 1'b0);
      expect_out("byte_rev", 64'h00000000_FF7F2A17, 1'b0);
      send(32'h00000001, 3'd0, 1'b0);
      expect_out("bit_rev", 64'h00000000_80000000, 1'b0);
      send(32'h12345678, 3'd4, 1'b0);
      expect_out("half_rev", 64'h00000000_56781234, 1'b0);
      send(32'h172A7FFF, 3'd3, 1'b1);
      @(negedge clk);
      check("pair_first_no_out", 64'(out_valid), 64'(0));
      check("pair_first_busy", 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      send(32'h01020304, 3'd3, 1'b1);
      expect_out("pair_byte", 64'h04030201_FF7F2A17, 1'b1);
      send(32'h172A7FFF, 3'd7, 1'b1);
      send(32'h01020304, 3'd3, 1'b0);
      expect_out("pair_pass", 64'h172A7FFF_01020304, 1'b1);
      out_ready = 0;
      send(32'hDEADBEEF, 3'd3, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_data", out_data, 64'h00000000_EFBEADDE);
      end
      @(posedge clk);
      #1 out_ready = 1;
      send(32'h11223344, 3'd3, 1'b0);
      send(32'h80000000, 3'd0, 1'b0);
      send(32'hCAFEF00D, 3'd2, 1'b0);
      expect_out("b2b_last", 64'h00000000_D00FEFAC, 1'b0);
      send(32'h12345678, 3'd3, 1'b1);
      rst_n = 0;
      @(negedge clk);
      check("rst_hold_valid", 64'(out_valid), 64'(0));
      check("rst_hold_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1 rst_n = 1;
      send(32'hAABBCCDD, 3'd3, 1'b1);
      send(32'h11223344, 3'd3, 1'b1);
      expect_out("post_rst_pair", 64'h44332211_DDCCBBAA, 1'b1);
      for (int i = 0; i < 65534; i++)
         send(i * 32'h9E3779B9, 3'(i), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("cnt_max", 64'(op_count), 64'hFFFF);
      @(posedge clk);
      #1;
      send(32'h172A7FFF, 3'd3, 1'b0);
      expect_out("wrap_res", 64'h00000000_FF7F2A17, 1'b0);
      @(negedge clk);
      check("cnt_wrap", 64'(op_count), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
